// File: rtl/imem_responder.sv
// imem_responder: memory-side responder for the fetch/LSU request port.
// Accepts one read or byte-masked write per handshake and returns a single
// one-cycle valid strobe (with read data or error) a fixed Latency cycles later.
//
// Ports:
//   clk       - clock, all state on rising edge
//   rst       - synchronous active-high reset
//   request   - transaction request, taken when ready=1
//   we_re     - 1 = write, 0 = read
//   mask      - byte enables for writes (bit i -> data bits [8i+7:8i])
//   address   - byte address; word index = address[log2(Depth)+1:2]
//   data_in   - write data
//   ready     - responder can accept a request this cycle (decoded from state)
//   valid     - one-cycle response strobe (registered)
//   data_out  - read data, zero unless valid (registered)
//   error     - misaligned/out-of-range access, qualified by valid (registered)
module imem_responder #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 1024,
  parameter int unsigned Latency   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 request,
  input  logic                 we_re,
  input  logic [3:0]           mask,
  input  logic [DataWidth-1:0] address,
  input  logic [DataWidth-1:0] data_in,
  output logic                 ready,
  output logic                 valid,
  output logic [DataWidth-1:0] data_out,
  output logic                 error
);

  localparam int unsigned IdxW = $clog2(Depth);
  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [DataWidth-1:0] mem [Depth];
  logic [DataWidth-1:0] resp_data_q;
  logic                 resp_err_q;
  logic [DataWidth-1:0] rd_val;
  logic [DataWidth-1:0] word_addr;
  logic [IdxW-1:0]      index;
  logic                 accept;
  logic                 error_cond;

  // Handshake and address decode
  assign ready      = !rst && (state_q == IDLE || state_q == RESP);
  assign accept     = ready && request;
  assign index      = address[IdxW+1:2];
  assign word_addr  = address >> 2;
  assign error_cond = (address[1:0] != 2'b00) || (word_addr >= DataWidth'(Depth));

  // Response payload captured at the accept edge; writes and errors return zero
  always_comb begin
    rd_val = '0;
    if (!we_re && !error_cond) rd_val = mem[index];
  end

  // Next-state logic; counter counts down the WAIT cycles
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          cnt_d   = CntW'(Latency - 1);
          state_d = (Latency == 1) ? RESP : WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      valid       <= 1'b0;
      data_out    <= '0;
      error       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        resp_data_q <= rd_val;
        resp_err_q  <= error_cond;
      end
      // With Latency=1 the accept and RESP entry share an edge, so bypass
      valid    <= (state_d == RESP);
      data_out <= (state_d == RESP) ? (accept ? rd_val : resp_data_q) : '0;
      error    <= (state_d == RESP) ? (accept ? error_cond : resp_err_q) : 1'b0;
    end
  end

  // Byte-masked write; never on error or during reset (accept excludes rst)
  always_ff @(posedge clk) begin
    if (accept && we_re && !error_cond) begin
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) mem[index][8*i +: 8] <= data_in[8*i +: 8];
      end
    end
  end

endmodule

// File: doc/imem_responder.md
# imem_responder

Memory-side responder for the core's instruction/data request interface. It accepts a request/we_re/mask/address transaction from the fetch unit (or LSU), performs a word-wide read or byte-masked write on an internal synchronous memory array, and returns a single-cycle valid with read data after a fixed, parameterised latency. It sits on the far side of the fetch unit's request port. Its data_out and valid drive the fetch unit's instruction_fetch and valid inputs.

## Interface
- DataWidth, 32, data and address width in bits
- Depth, 1024, number of DataWidth-bit words in the array (power of two)
- Latency, 2, cycles from request acceptance to valid; legal range 1..15

- clk  input  1  single clock, all state on rising edge
- rst  input  1  reset, synchronous and active-high
- request  input  1  transaction request, sampled when ready=1
- we_re  input  1  1 = write, 0 = read
- mask  input  4  byte enables for writes; bit i covers data bits [8i+7:8i]; ignored on reads
- address  input  DataWidth  byte address; word index = address[log2(Depth)+1:2]
- data_in  input  DataWidth  write data
- ready  output  1  responder can accept a request this cycle
- valid  output  1  one-cycle response strobe
- data_out  output  DataWidth  read data, qualified by valid
- error  output  1  response is for a misaligned or out-of-range access, qualified by valid

## Operation
- **States:** IDLE, WAIT, RESP.
- **ready:** high in IDLE and RESP; low in WAIT; low while rst=1.
- **Accept:** happens at a rising edge with ready=1 and request=1. At that edge:
  - address, we_re, mask and data_in are captured.
  - Reads latch mem[index] into the response register.
  - Writes update mem[index] bytewise per mask.
  - The counter loads Latency-1.
- **Error check:** error_cond = (address[1:0] != 0) or (address >> 2 >= Depth). When error_cond is true:
  - No write occurs.
  - The response carries error=1 and data_out=0.
- **Write responses:** data_out=0, error=0 unless error_cond.
- **mask=0 write:** no byte changes; still responds with valid.
- **Transitions:**
  - IDLE: on accept, go to RESP if Latency=1, else WAIT.
  - WAIT: decrement the counter; when the counter reaches 1, go to RESP.
  - RESP: assert valid for exactly this cycle. If request=1, accept a new transaction, going to WAIT (or to RESP if Latency=1). Otherwise go to IDLE.
- **Outputs in IDLE/WAIT:** data_out, error and valid are held at 0. data_out is non-zero only with valid.
- **Reset:**
  - State goes to IDLE and the counter to 0.
  - valid=0, data_out=0, error=0.
  - Memory contents are not cleared.
  - Reset during WAIT or RESP cancels the pending response; no valid is issued.
  - A write committed at an earlier accept edge persists.
- **Simultaneous events:** rst=1 with request=1 means reset wins; nothing is accepted and nothing is written.

## Timing
- Request high in cycle N with ready=1 gives valid high in cycle N+Latency, for exactly one cycle.
- All outputs are registered except ready, which is decoded from state and rst.
- **Throughput:**
  - One transaction every Latency cycles when request is held high, via back-to-back accept in RESP.
  - Latency=1 with request held high gives valid every cycle.
- Read data reflects memory at the accept edge. A write accepted in RESP is not visible to the read whose response is being presented in that cycle.
- The requester must hold request/address stable until it sees ready=1 at a rising edge. Inputs are don't-care while ready=0.

## Test plan
- **Reset:** hold rst 2 cycles with request=1 -> valid=0, data_out=0, error=0, ready=0 during reset; ready=1 the first cycle after.
- **Latency=2 read:** preload mem[4]=0xDEADBEEF. Pulse request, we_re=0, address=0x10 in cycle N -> ready=0 in N+1; valid=1, data_out=0xDEADBEEF, error=0 in N+2 only.
- **Masked write:** mem[1]=0x11223344. Write address=0x4, mask=4'b0101, data_in=0xAABBCCDD -> write response data_out=0. A following read of 0x4 returns 0x11BB33DD.
- **Errors:**
  - Read address=0x6 -> valid with error=1, data_out=0.
  - Write address=Depth*4 -> error=1, and no word in the array changes.
- **Back-to-back:** request held high for reads of 0x0, 0x4, 0x8 -> valids in cycles N+2, N+4, N+6 with the correct data. With Latency=1, valid every cycle.
- **Reset mid-op:** assert rst in the WAIT cycle of a read -> no valid afterwards; state returns to IDLE and ready=1 the cycle after rst deasserts.
